// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter : iterative signed divider (radix-2 restoring, fabric logic only)
//
// Divides a WIDTH_N-bit two's-complement dividend by a WIDTH_D-bit
// two's-complement divisor. The quotient is truncated toward zero and the
// remainder takes the dividend's sign, so n = q*d + r with |r| < |d|.
// One division is in flight at a time. Valid/ready handshakes are used on
// both sides.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   in_valid     in   dividend/divisor valid
//   in_ready     out  block can accept an operation (IDLE only)
//   din_n        in   WIDTH_N signed dividend
//   din_d        in   WIDTH_D signed divisor
//   out_valid    out  result valid (DONE only)
//   out_ready    in   downstream accepts result
//   dout_q       out  WIDTH_N signed quotient
//   dout_r       out  WIDTH_D signed remainder
//   div_by_zero  out  divisor was zero (q = all ones, r = low dividend bits)
//   overflow     out  most-negative dividend / -1 (q = max positive, r = 0)
//
// Optional build macro DIV_ZERO_FAST_EN: divide-by-zero and overflow
// operations skip CALC (PREP -> FIX). Without it every operation takes the
// same WIDTH_N+3 cycle latency.
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] din_n,
    input  logic [WIDTH_D-1:0] din_d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_N-1:0] dout_q,
    output logic [WIDTH_D-1:0] dout_r,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

    localparam logic signed [WIDTH_N-1:0] N_MIN = {1'b1, {(WIDTH_N-1){1'b0}}};
    localparam logic signed [WIDTH_N-1:0] N_MAX = {1'b0, {(WIDTH_N-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operand capture and working registers (datapath, not reset)
    logic signed [WIDTH_N-1:0] r_n;
    logic signed [WIDTH_D-1:0] r_d;
    logic                      r_sn;
    logic                      r_sd;
    logic                      r_dz;
    logic                      r_ovf;
    logic [WIDTH_N-1:0]        r_work;   // dividend bits out at MSB, quotient bits in at LSB
    logic [WIDTH_D:0]          r_dmag;
    logic [WIDTH_D:0]          r_rem;
    logic [CNT_W-1:0]          r_cnt;

    // Result registers (reset to zero)
    logic signed [WIDTH_N-1:0] r_q;
    logic signed [WIDTH_D-1:0] r_r;
    logic                      r_dz_o;
    logic                      r_ovf_o;

    logic                      w_dz;
    logic                      w_ovf;
    logic [WIDTH_N-1:0]        w_n_mag;
    logic signed [WIDTH_D:0]   w_d_ext;
    logic [WIDTH_D:0]          w_d_mag;
    logic [WIDTH_D+1:0]        w_shift;
    logic [WIDTH_D+1:0]        w_trial;
    logic                      w_qbit;
    logic signed [WIDTH_N-1:0] w_q_fix;
    logic signed [WIDTH_D-1:0] w_r_fix;

    // Sign restoration of the unsigned magnitudes.
    function automatic logic signed [WIDTH_N-1:0] f_sign_q(
        input logic [WIDTH_N-1:0] mag,
        input logic               neg
    );
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic signed [WIDTH_D-1:0] f_sign_r(
        input logic [WIDTH_D-1:0] mag,
        input logic               neg
    );
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    // Special-case detection on the captured operands (used in PREP).
    assign w_dz  = (r_d == '0);
    assign w_ovf = (r_n == N_MIN) && (r_d == '1);

    // The dividend magnitude 2^(N-1) is representable as an unsigned N-bit
    // value, so the negated pattern of N_MIN is already the right magnitude.
    assign w_n_mag = r_n[WIDTH_N-1] ? WIDTH_N'(-r_n) : WIDTH_N'(r_n);

    // Divisor is widened by one bit so that |-2^(D-1)| does not wrap.
    assign w_d_ext = {r_d[WIDTH_D-1], r_d};
    assign w_d_mag = w_d_ext[WIDTH_D] ? WIDTH_D'(0) + (-w_d_ext) : w_d_ext;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    assign w_shift = {r_rem, r_work[WIDTH_N-1]};
    assign w_trial = w_shift - {1'b0, r_dmag};
    assign w_qbit  = ~w_trial[WIDTH_D+1];

    assign w_q_fix = f_sign_q(r_work, r_sn ^ r_sd);
    assign w_r_fix = f_sign_r(r_rem[WIDTH_D-1:0], r_sn);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
`ifdef DIV_ZERO_FAST_EN
                if (w_dz || w_ovf) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_CALC;
                end
`else
                w_next = S_CALC;
`endif
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Working datapath: capture -> prepare magnitudes -> iterate
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    r_n <= din_n;
                    r_d <= din_d;
                end
            end
            S_PREP: begin
                r_sn   <= r_n[WIDTH_N-1];
                r_sd   <= r_d[WIDTH_D-1];
                r_work <= w_n_mag;
                r_dmag <= w_d_mag;
                r_rem  <= '0;
                r_dz   <= w_dz;
                r_ovf  <= w_ovf;
`ifdef DIV_ZERO_FAST_EN
                if (!(w_dz || w_ovf)) begin
                    r_cnt <= CNT_W'(WIDTH_N - 1);
                end
`else
                r_cnt  <= CNT_W'(WIDTH_N - 1);
`endif
            end
            S_CALC: begin
                r_rem  <= w_qbit ? w_trial[WIDTH_D:0] : w_shift[WIDTH_D:0];
                r_work <= {r_work[WIDTH_N-2:0], w_qbit};
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Result stage: sign fix, then special cases override
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            r_r     <= '0;
            r_dz_o  <= 1'b0;
            r_ovf_o <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_dz_o  <= r_dz;
            r_ovf_o <= r_ovf;
            if (r_dz) begin
                r_q <= '1;
                r_r <= r_n[WIDTH_D-1:0];
            end else if (r_ovf) begin
                r_q <= N_MAX;
                r_r <= '0;
            end else begin
                r_q <= w_q_fix;
                r_r <= w_r_fix;
            end
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign dout_q      = r_q;
    assign dout_r      = r_r;
    assign div_by_zero = r_dz_o;
    assign overflow    = r_ovf_o;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter : self-checking bench for div_iter (WIDTH_N=16, WIDTH_D=8).
// Directed operations from the test plan, backpressure, mid-division reset,
// then randomized operands, all checked against an integer reference model.
// -----------------------------------------------------------------------------
module tb_div_iter;

    localparam int N = 16;
    localparam int D = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] din_n;
    logic [D-1:0] din_d;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] dout_q;
    logic [D-1:0] dout_r;
    logic         div_by_zero;
    logic         overflow;

    int n_chk;
    int n_err;

    div_iter #(
        .WIDTH_N(N),
        .WIDTH_D(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din_n      (din_n),
        .din_d      (din_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout_q     (dout_q),
        .dout_r     (dout_r),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division (truncating) plus the two special cases.
    function automatic void model(input int n, input int d,
                                  output logic [N-1:0] q, output logic [D-1:0] r,
                                  output logic dz, output logic ov);
        dz = 1'b0;
        ov = 1'b0;
        if (d == 0) begin
            dz = 1'b1;
            q  = '1;
            r  = D'(n);
        end else if (n == -32768 && d == -1) begin
            ov = 1'b1;
            q  = 16'h7FFF;
            r  = '0;
        end else begin
            q = N'(n / d);
            r = D'(n % d);
        end
    endfunction

    task automatic run_op(input logic signed [N-1:0] n, input logic signed [D-1:0] d, input int hold);
        logic [N-1:0] eq;
        logic [D-1:0] er;
        logic         edz;
        logic         eov;
        logic [N-1:0] q0;
        logic [D-1:0] r0;
        int           el;
        int           lat;
        int           w;
        model(int'(n), int'(d), eq, er, edz, eov);
        el = N + 3;
`ifdef DIV_ZERO_FAST_EN
        if (edz || eov) el = 3;
`endif
        @(negedge clk);
        din_n    = n;
        din_d    = d;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        check("latency", lat, el);
        check("q", dout_q, eq);
        check("r", dout_r, er);
        check("div_by_zero", div_by_zero, edz);
        check("overflow", overflow, eov);
        q0 = dout_q;
        r0 = dout_r;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            din_n    = N'($urandom);
            din_d    = D'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_q", dout_q, q0);
            check("hold_r", dout_r, r0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic signed [N-1:0] rn;
        logic signed [D-1:0] rd;
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din_n     = '0;
        din_d     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", dout_q, 0);
        check("rst_r", dout_r, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_ov", overflow, 0);

        run_op(16'sd1000, 8'sd7, 0);
        run_op(-16'sd1000, 8'sd7, 1);
        run_op(16'sd1000, -8'sd7, 0);
        run_op(16'sd100, 8'sd0, 0);
        run_op(-16'sd32768, -8'sd1, 0);
        run_op(-16'sd32768, 8'sd1, 0);
        run_op(-16'sd32768, -8'sd128, 2);
        run_op(16'sd1234, -8'sd5, 5);
        run_op(16'sd1000, 8'sd7, 0);

        // Reset during CALC of 200/3 aborts the division.
        @(negedge clk);
        din_n    = 16'd200;
        din_d    = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_q", dout_q, 0);
        check("abort_r", dout_r, 0);
        check("abort_dz", div_by_zero, 0);
        check("abort_ov", overflow, 0);
        run_op(16'sd200, 8'sd3, 0);

        for (int k = 0; k < 40; k++) begin
            rn = N'($urandom);
            case ($urandom_range(0, 9))
                0:       rd = '0;
                1:       begin rn = -16'sd32768; rd = -8'sd1; end
                2:       rd = -8'sd128;
                default: rd = D'($urandom);
            endcase
            run_op(rn, rd, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
